div_unit: RTL and testbench

//  Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU, driven from the execute stage.

---
 rtl/div_unit.sv | 167 ++++++++++++++++
 tb/tb_div_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU. One request is
//   accepted in IDLE. The pipeline is held while the divider steps once per
//   bit, and the quotient (lo_o) and remainder (hi_o) are then presented with
//   a one-cycle valid_o strobe.
//
//   Ports
//     clk       rising-edge clock
//     rst       asynchronous, active-low reset
//     start_i   DIV/DIVU request from execute; sampled only in IDLE
//     signed_i  1 = DIV (two's complement), 0 = DIVU; sampled with start_i
//     a_i       dividend (rs)
//     b_i       divisor (rt)
//     annul_i   flush of the divide instruction; aborts the operation
//     stall_o   freeze PC/IF/ID/EX while the divide is in progress
//     busy_o    FSM not in IDLE
//     valid_o   one-cycle pulse, hi_o/lo_o hold the final result
//     hi_o      remainder
//     lo_o      quotient
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start_i; operands are captured as magnitudes
//   CALC  | one restoring step per cycle, WIDTH steps in total
//   DONE  | result registered; valid_o pulses unless annulled
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             annul_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] step_rem, step_quo;

  always_comb begin
    accept = start_i & ~annul_i;

    a_mag = (signed_i & a_i[WIDTH-1]) ? (~a_i + ONE) : a_i;
    b_mag = (signed_i & b_i[WIDTH-1]) ? (~b_i + ONE) : b_i;

    // Shift the next dividend bit into the partial remainder. The extra top
    // bit keeps the compare exact; when the subtract is taken the difference
    // is below the divisor, so the low WIDTH bits hold it without loss.
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, div_q});
    rem_sub  = rem_sh[WIDTH-1:0] - div_q;
    step_rem = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], rem_ge};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_CALC;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = a_mag;
          div_d     = b_mag;
          neg_quo_d = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          neg_rem_d = signed_i & a_i[WIDTH-1];
        end
      end
      ST_CALC: begin
        if (annul_i) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            // Final step: sign-fix the just-computed values straight into
            // the output registers so they are valid on DONE entry.
            state_d = ST_DONE;
            lo_d    = neg_quo_q ? (~step_quo + ONE) : step_quo;
            hi_d    = neg_rem_q ? (~step_rem + ONE) : step_rem;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Stall drops in DONE so the divide leaves EX in the cycle valid_o pulses.
  assign stall_o = ((state_q == ST_IDLE) & accept) | (state_q == ST_CALC);
  assign busy_o  = (state_q != ST_IDLE);
  assign valid_o = (state_q == ST_DONE) & ~annul_i;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
//   Directed bench for div_unit (WIDTH = 32). Inputs change on the falling
//   edge; outputs are sampled on the falling edge (or #1 after an input
//   change for combinational outputs). Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic         signed_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         annul_i;
  logic         stall_o;
  logic         busy_o;
  logic         valid_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int n_cmp = 0;
  int n_err = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .annul_i  (annul_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full divide: start for one cycle, count stall/latency, check result.
  // A nonzero inject cycle pulses a competing start while busy.
  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                         input string name, input int inject);
    int cycles;
    int stalls;
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; a_i = a; b_i = b;
    #1;
    stalls = stall_o ? 1 : 0;
    @(negedge clk);
    start_i = 1'b0; a_i = '0; b_i = '0;
    cycles = 1;
    while (!valid_o && cycles < 60) begin
      if (cycles == inject) begin
        start_i = 1'b1; signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3;
      end
      #1;
      if (stall_o) stalls++;
      @(negedge clk);
      start_i = 1'b0; a_i = '0; b_i = '0;
      cycles++;
    end
    #1;
    n_cmp++;
    if (cycles !== 33) begin
      n_err++; $display("FAIL %s latency: got %0d cycles, want 33", name, cycles);
    end
    n_cmp++;
    if (stalls !== 33) begin
      n_err++; $display("FAIL %s stall_count: got %0d, want 33", name, stalls);
    end
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_err++; $display("FAIL %s stall_in_done: got %b, want 0", name, stall_o);
    end
    n_cmp++;
    if (lo_o !== exp_lo) begin
      n_err++; $display("FAIL %s lo: got %h, want %h", name, lo_o, exp_lo);
    end
    n_cmp++;
    if (hi_o !== exp_hi) begin
      n_err++; $display("FAIL %s hi: got %h, want %h", name, hi_o, exp_hi);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy_o, valid_o} !== 2'b00) begin
      n_err++; $display("FAIL %s back_to_idle: busy/valid got %b, want 00", name, {busy_o, valid_o});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; signed_i = 1'b0; a_i = '0; b_i = '0; annul_i = 1'b0;
    #2;
    n_cmp++;
    if ({stall_o, busy_o, valid_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl: got %b, want 000", {stall_o, busy_o, valid_o});
    end
    n_cmp++;
    if ({hi_o, lo_o} !== 64'h0) begin
      n_err++; $display("FAIL reset_hilo: got %h/%h, want 0/0", hi_o, lo_o);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_unsigned();
    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "divu_100_7", 0);
    run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, "divu_big_2", 0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, "divu_max_1", 0);
  endtask

  task automatic test_signed();
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2", 0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, "div_7_m2", 0);
    run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, "div_m100_m7", 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "div_overflow", 0);
  endtask

  task automatic test_div_zero();
    run_div(1'b0, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, "divu_7_0", 0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd0, 32'd1, 32'hFFFF_FFF9, "div_m7_0", 0);
  endtask

  task automatic test_abort();
    bit saw_valid;
    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "abort_setup", 0);
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    annul_i = 1'b1;
    #1;
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_err++; $display("FAIL abort_busy_before: got %b, want 1", busy_o);
    end
    @(negedge clk);
    annul_i = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, stall_o} !== 2'b00) begin
      n_err++; $display("FAIL abort_idle: busy/stall got %b, want 00", {busy_o, stall_o});
    end
    saw_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid_o) saw_valid = 1'b1;
    end
    n_cmp++;
    if (saw_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_no_valid: got valid seen=%b, want 0", saw_valid);
    end
    n_cmp++;
    if ({hi_o, lo_o} !== {32'd2, 32'd14}) begin
      n_err++; $display("FAIL abort_hilo_kept: got %h/%h, want 00000002/0000000e", hi_o, lo_o);
    end
    run_div(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, "after_abort", 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd100; b_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 1; c < 5; c++) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({stall_o, busy_o, valid_o, hi_o, lo_o} !== 67'h0) begin
      n_err++; $display("FAIL reset_mid: got stall=%b busy=%b valid=%b hi=%h lo=%h, want all 0",
                        stall_o, busy_o, valid_o, hi_o, lo_o);
    end
    @(negedge clk);
    rst = 1'b1;
    run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, "after_reset", 0);
  endtask

  task automatic test_start_annul();
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd100; b_i = 32'd7; annul_i = 1'b1;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_err++; $display("FAIL start_annul_stall: got %b, want 0", stall_o);
    end
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, valid_o} !== 2'b00) begin
      n_err++; $display("FAIL start_annul_idle: busy/valid got %b, want 00", {busy_o, valid_o});
    end
  endtask

  task automatic test_annul_done();
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd100; b_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 1; c < 33; c++) @(negedge clk);
    annul_i = 1'b1;
    #1;
    n_cmp++;
    if ({busy_o, valid_o} !== 2'b10) begin
      n_err++; $display("FAIL annul_done: busy/valid got %b, want 10", {busy_o, valid_o});
    end
    @(negedge clk);
    annul_i = 1'b0;
    #1;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++; $display("FAIL annul_done_idle: busy got %b, want 0", busy_o);
    end
  endtask

  task automatic test_back_to_back();
    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "start_while_busy", 5);
    run_div(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, "back_to_back", 0);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_abort();
    test_reset_mid();
    test_start_annul();
    test_annul_done();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
